// File: rtl/space_invaders_pkg.sv
// Shared types and screen constants for the space-invaders game blocks.
package space_invaders_pkg;

  typedef logic [10:0] coord_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  typedef struct packed {
    logic   active;
    logic   hit;
    coord_t x;
    coord_t y;
  } missile_slot_t;

endpackage

// File: rtl/monster_missiles_if.sv
// Frame, pixel, fire and player signals exchanged with the missile pool.
interface monster_missiles_if;
  import space_invaders_pkg::*;

  logic   enable;
  logic   startOfFrame;
  coord_t pixelX;
  coord_t pixelY;
  logic   fire_req;
  coord_t fire_x;
  coord_t fire_y;
  logic   player_draw;
  logic   player_dead;
  logic   fire_ack;
  logic   missile_draw;
  logic   missile_collision;

  modport master (
    output enable, startOfFrame, pixelX, pixelY, fire_req, fire_x, fire_y,
           player_draw, player_dead,
    input  fire_ack, missile_draw, missile_collision
  );

  modport slave (
    input  enable, startOfFrame, pixelX, pixelY, fire_req, fire_x, fire_y,
           player_draw, player_dead,
    output fire_ack, missile_draw, missile_collision
  );

endinterface

// File: rtl/missile_slot.sv
// One missile: position/flag registers, per-frame movement and retire,
// and the combinational pixel-coverage compare.
module missile_slot
  import space_invaders_pkg::*;
#(
  parameter int MISSILE_WIDTH  = 4,
  parameter int MISSILE_HEIGHT = 8,
  parameter int MISSILE_SPEED  = 4,
  parameter int RETIRE_Y       = 480
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   enable_i,
  input  logic   sof_i,
  input  logic   alloc_i,
  input  coord_t alloc_x_i,
  input  coord_t alloc_y_i,
  input  coord_t pixel_x_i,
  input  coord_t pixel_y_i,
  input  logic   set_hit_i,
  output logic   active_o,
  output logic   pix_hit_o
);

  missile_slot_t slot_q, slot_d;
  logic [11:0]   moved_y;
  logic [11:0]   x_ext, y_ext, px_ext, py_ext;

  // Widen by one bit so y+SPEED and x+WIDTH cannot wrap near the 11-bit limit.
  assign moved_y = {1'b0, slot_q.y} + 12'(MISSILE_SPEED);
  assign x_ext   = {1'b0, slot_q.x};
  assign y_ext   = {1'b0, slot_q.y};
  assign px_ext  = {1'b0, pixel_x_i};
  assign py_ext  = {1'b0, pixel_y_i};

  // NOTE: every always_comb output gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d = slot_q;
    if (enable_i) begin
      if (alloc_i) begin
        slot_d = '{active: 1'b1, hit: 1'b0, x: alloc_x_i, y: alloc_y_i};
      end else if (slot_q.active) begin
        if (sof_i) begin
          if (moved_y >= 12'(RETIRE_Y) || slot_q.hit) begin
            slot_d.active = 1'b0;
            slot_d.hit    = 1'b0;
          end else begin
            slot_d.y   = moved_y[10:0];
            slot_d.hit = set_hit_i;
          end
        end else if (set_hit_i) begin
          slot_d.hit = 1'b1;
        end
      end
    end
  end

  // NOTE: these are a handful of flops rather than a RAM, so the whole record takes the async reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) slot_q <= '0;
    else         slot_q <= slot_d;
  end

  assign active_o  = slot_q.active;
  assign pix_hit_o = slot_q.active
                   && (px_ext >= x_ext) && (px_ext < x_ext + 12'(MISSILE_WIDTH))
                   && (py_ext >= y_ext) && (py_ext < y_ext + 12'(MISSILE_HEIGHT));

endmodule

// File: rtl/monster_missiles.sv
// Enemy-missile pool: lowest-free-slot allocator, launch cooldown,
// once-per-frame collision report and registered draw/ack/collision outputs.
module monster_missiles #(
  parameter int MISSILE_SLOTS        = 4,
  parameter int MISSILE_WIDTH        = 4,
  parameter int MISSILE_HEIGHT       = 8,
  parameter int MISSILE_SPEED        = 4,
  parameter int FIRE_COOLDOWN_FRAMES = 20,
  parameter int SCREEN_HEIGHT        = space_invaders_pkg::SCREEN_HEIGHT
) (
  input logic               clk,
  input logic               resetN,
  monster_missiles_if.slave bus
);

  logic [MISSILE_SLOTS-1:0] active, free, alloc_oh, pix_hit, set_hit;
  logic [5:0]               cooldown_q, cooldown_d;
  logic                     reported_q, reported_d;
  logic                     ack_q, draw_q, coll_q;
  logic                     launch, pulse;

  assign free   = ~active;
  assign launch = bus.enable && bus.fire_req && !bus.player_dead
                && (cooldown_q == '0) && (|free);
  // Isolating the lowest set bit of the free mask picks the lowest-index free slot.
  assign alloc_oh = launch ? (free & (~free + MISSILE_SLOTS'(1))) : '0;
  assign set_hit  = pix_hit
                  & {MISSILE_SLOTS{bus.enable && bus.player_draw && !bus.player_dead}};
  // A collision in the frame-start cycle belongs to the new frame, so the old latch is ignored.
  assign pulse    = (|set_hit) && (!reported_q || bus.startOfFrame);

  for (genvar i = 0; i < MISSILE_SLOTS; i++) begin : g_slot
    missile_slot #(
      .MISSILE_WIDTH (MISSILE_WIDTH),
      .MISSILE_HEIGHT(MISSILE_HEIGHT),
      .MISSILE_SPEED (MISSILE_SPEED),
      .RETIRE_Y      (SCREEN_HEIGHT)
    ) u_slot (
      .clk      (clk),
      .resetN   (resetN),
      .enable_i (bus.enable),
      .sof_i    (bus.startOfFrame),
      .alloc_i  (alloc_oh[i]),
      .alloc_x_i(bus.fire_x),
      .alloc_y_i(bus.fire_y),
      .pixel_x_i(bus.pixelX),
      .pixel_y_i(bus.pixelY),
      .set_hit_i(set_hit[i]),
      .active_o (active[i]),
      .pix_hit_o(pix_hit[i])
    );
  end

  always_comb begin
    cooldown_d = cooldown_q;
    reported_d = reported_q;
    if (bus.enable) begin
      if (launch)                                   cooldown_d = 6'(FIRE_COOLDOWN_FRAMES);
      else if (bus.startOfFrame && cooldown_q != '0) cooldown_d = cooldown_q - 6'd1;
      if (bus.startOfFrame) reported_d = 1'b0;
      if (pulse)            reported_d = 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown_q <= '0;
      reported_q <= 1'b0;
      ack_q      <= 1'b0;
      draw_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      cooldown_q <= cooldown_d;
      reported_q <= reported_d;
      ack_q      <= launch;
      draw_q     <= |pix_hit;
      coll_q     <= pulse;
    end
  end

  assign bus.fire_ack          = ack_q;
  assign bus.missile_draw      = draw_q;
  assign bus.missile_collision = coll_q;

endmodule

// File: tb/tb_monster_missiles.sv
// Directed bench for the missile pool: pixel-coverage table plus
// launch, cooldown, retire, collision, full-pool, gating and reset sequences.
module tb_monster_missiles;

  logic clk = 1'b0;
  logic resetN;
  int   n_cmp = 0;
  int   n_err = 0;

  monster_missiles_if bus ();

  monster_missiles dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   px;
    int   py;
    logic exp_draw;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
  endtask

  task automatic do_reset();
    resetN           = 1'b0;
    bus.enable       = 1'b1;
    bus.startOfFrame = 1'b0;
    set_pix(2000, 2000);
    bus.fire_req     = 1'b0;
    bus.fire_x       = '0;
    bus.fire_y       = '0;
    bus.player_draw  = 1'b0;
    bus.player_dead  = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic launch_at(input int x, input int y, input string name);
    bus.fire_x   = 11'(x);
    bus.fire_y   = 11'(y);
    bus.fire_req = 1'b1;
    tick();
    bus.fire_req = 1'b0;
    check(name, int'(bus.fire_ack), 1);
  endtask

  task automatic draw_at(input int x, input int y, input int exp, input string name);
    set_pix(x, y);
    tick();
    check(name, int'(bus.missile_draw), exp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int got;

    vecs[0] = '{99,  50, 1'b0};
    vecs[1] = '{100, 50, 1'b1};
    vecs[2] = '{103, 50, 1'b1};
    vecs[3] = '{104, 50, 1'b0};
    vecs[4] = '{100, 49, 1'b0};
    vecs[5] = '{100, 57, 1'b1};
    vecs[6] = '{100, 58, 1'b0};
    vecs[7] = '{101, 53, 1'b1};
    vecs[8] = '{103, 57, 1'b1};
    vecs[9] = '{50,  50, 1'b0};

    // Reset state
    do_reset();
    check("reset_ack",  int'(bus.fire_ack), 0);
    check("reset_draw", int'(bus.missile_draw), 0);
    check("reset_coll", int'(bus.missile_collision), 0);

    // 1. Launch and pixel coverage
    launch_at(100, 50, "launch_ack");
    tick();
    check("ack_one_cycle", int'(bus.fire_ack), 0);
    for (int i = 0; i < 10; i++) begin
      set_pix(vecs[i].px, vecs[i].py);
      tick();
      check($sformatf("draw_vec%0d", i), int'(bus.missile_draw), int'(vecs[i].exp_draw));
    end
    set_pix(2000, 2000);

    // 2. Cooldown: held request acked only after 20 frames
    bus.fire_x   = 11'd200;
    bus.fire_y   = 11'd100;
    bus.fire_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      sof_pulse();
      if (bus.fire_ack) acks++;
    end
    check("no_ack_in_cooldown", acks, 0);
    tick();
    bus.fire_req = 1'b0;
    check("ack_after_cooldown", int'(bus.fire_ack), 1);
    draw_at(200, 100, 1, "slot1_draw");
    draw_at(100, 130, 1, "slot0_moved_draw");
    draw_at(100, 50, 0, "slot0_old_pos");

    // 3. Movement and retire at the bottom edge
    do_reset();
    launch_at(300, 472, "launch_low_ack");
    draw_at(300, 472, 1, "low_draw_472");
    sof_pulse();
    draw_at(300, 476, 1, "moved_draw_476");
    draw_at(300, 475, 0, "moved_draw_475");
    sof_pulse();
    draw_at(300, 479, 0, "retired_draw");

    // 4. Collision with two overlapping slots: one pulse per frame
    do_reset();
    launch_at(100, 50, "coll_launch_a");
    for (int i = 0; i < 20; i++) sof_pulse();
    launch_at(100, 130, "coll_launch_b");
    set_pix(101, 131);
    bus.player_draw = 1'b1;
    tick();
    check("coll_pulse", int'(bus.missile_collision), 1);
    tick();
    check("coll_no_repeat", int'(bus.missile_collision), 0);
    set_pix(102, 135);
    tick();
    check("coll_no_second_pixel", int'(bus.missile_collision), 0);
    bus.player_draw = 1'b0;
    draw_at(100, 130, 1, "hit_keeps_drawing");
    sof_pulse();
    check("coll_after_sof", int'(bus.missile_collision), 0);
    draw_at(100, 134, 0, "hit_slots_retired");
    draw_at(100, 130, 0, "hit_slots_gone");

    // 5. Full pool rejects, freed slot reused
    do_reset();
    for (int s = 0; s < 4; s++) begin
      launch_at(s * 20, 0, $sformatf("pool_launch%0d", s));
      for (int i = 0; i < 20; i++) sof_pulse();
    end
    bus.fire_x   = 11'd500;
    bus.fire_y   = 11'd10;
    bus.fire_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.fire_ack) acks++;
    end
    check("full_pool_no_ack", acks, 0);
    got = 0;
    for (int k = 1; k <= 60; k++) begin
      if (got == 0) begin
        sof_pulse();
        if (bus.fire_ack) got = k;
      end
    end
    bus.fire_req = 1'b0;
    check("freed_slot_ack_frame", got, 41);
    draw_at(500, 10, 1, "freed_slot_unmoved");
    draw_at(0, 480, 0, "slot0_old_gone");

    // 6. player_dead / enable gating, then async reset mid-flight
    do_reset();
    bus.fire_x      = 11'd100;
    bus.fire_y      = 11'd50;
    bus.fire_req    = 1'b1;
    bus.player_dead = 1'b1;
    tick();
    check("dead_no_ack", int'(bus.fire_ack), 0);
    bus.player_dead = 1'b0;
    bus.enable      = 1'b0;
    tick();
    check("disabled_no_ack", int'(bus.fire_ack), 0);
    bus.enable = 1'b1;
    tick();
    bus.fire_req = 1'b0;
    check("enabled_ack", int'(bus.fire_ack), 1);
    set_pix(100, 50);
    bus.player_draw = 1'b1;
    bus.player_dead = 1'b1;
    tick();
    check("dead_no_coll", int'(bus.missile_collision), 0);
    bus.player_dead = 1'b0;
    bus.enable      = 1'b0;
    tick();
    check("disabled_no_coll", int'(bus.missile_collision), 0);
    check("disabled_draw_tracks", int'(bus.missile_draw), 1);
    bus.enable = 1'b1;
    tick();
    check("live_coll", int'(bus.missile_collision), 1);
    bus.player_draw = 1'b0;
    resetN = 1'b0;
    #2;
    check("async_reset_draw", int'(bus.missile_draw), 0);
    check("async_reset_coll", int'(bus.missile_collision), 0);
    check("async_reset_ack",  int'(bus.fire_ack), 0);
    @(posedge clk);
    #1 resetN = 1'b1;
    tick();
    check("pool_empty_after_reset", int'(bus.missile_draw), 0);
    launch_at(300, 300, "cooldown_cleared_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
